fifo_line_reader: RTL and testbench

//  Read-side controller for the 32-bit x 1k pixel FIFO feeding MIPI TX. Waits until one full

---
 rtl/fifo_rd_pkg.sv | 23 ++
 rtl/rd_skid_buf.sv | 55 +++++
 rtl/fifo_line_reader.sv | 160 ++++++++++++++++
 tb/tb_fifo_line_reader.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared types and sizing helpers for the FIFO line reader.
package fifo_rd_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_FILL = 2'd1,
    READ      = 2'd2,
    DRAIN     = 2'd3
  } rd_state_e;

  // Width able to hold the values 0..depth (credit and occupancy counters).
  function automatic int cred_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Width of an index over n items, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// Small synchronous FIFO catching FIFO read data on the return path, so words
// already requested are never lost when the downstream stalls.
module rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic [cred_w(DEPTH)-1:0] count
);

  localparam int PTR_W = cnt_w(DEPTH);
  localparam int CNT_W = cred_w(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_wr;
  logic              do_rd;

  assign do_rd   = rd_en && (count != '0);
  assign do_wr   = wr_en && (count != CNT_FULL);
  assign rd_data = mem[rd_ptr];

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy tracking, flushed by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fifo_line_reader.sv
// Read-side controller for the pixel FIFO: waits for a full line, bursts one
// line of reads and presents the words as a framed valid/ready stream.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | no frame active, waiting for frame_start
//   WAIT_FILL | frame active, waiting until a whole line is buffered
//   READ      | issuing the line's reads, paced by FIFO data and credits
//   DRAIN     | all reads issued, waiting for the line's last word to leave
module fifo_line_reader
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int LINE_WORDS  = 810,
  parameter int FRAME_LINES = 1920,
  parameter int RD_LAT      = 2
) (
  input  logic              rclk,
  input  logic              rrst_n,
  input  logic              frame_start,
  input  logic              fifo_prog_empty,
  input  logic              fifo_rempty,
  output logic              fifo_ren,
  input  logic [DATA_W-1:0] fifo_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sol,
  output logic              out_eol,
  output logic              out_eof,
  output logic              busy,
  output logic              frame_done,
  output logic              underrun,
  output logic              start_err
);

  // Skid depth covers every word in flight plus slack for one stalled
  // cycle, so issuing against credits never overruns the buffer.
  localparam int SKID_DEPTH = RD_LAT + 2;
  localparam int CRED_W     = cred_w(SKID_DEPTH);
  localparam int WCNT_W     = $clog2(LINE_WORDS + 1);
  localparam int LINE_W     = cnt_w(FRAME_LINES);
  localparam logic [WCNT_W-1:0] WORD_LAST = WCNT_W'(LINE_WORDS - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(FRAME_LINES - 1);
  localparam logic [CRED_W-1:0] CRED_MAX  = CRED_W'(SKID_DEPTH);

  rd_state_e         state;
  rd_state_e         state_nxt;
  logic [WCNT_W-1:0] rd_cnt;
  logic [WCNT_W-1:0] out_cnt;
  logic [LINE_W-1:0] line_cnt;
  logic [RD_LAT-1:0] tag_pipe;
  logic [CRED_W-1:0] inflight;
  logic [CRED_W-1:0] skid_cnt;
  logic [CRED_W-1:0] credits;
  logic [DATA_W-1:0] skid_data;
  logic              accept;
  logic              last_word;
  logic              line_done;
  logic              start_ok;

  assign out_valid = (skid_cnt != '0);
  assign out_data  = out_valid ? skid_data : '0;
  assign accept    = out_valid && out_ready;
  assign last_word = (out_cnt == WORD_LAST);
  assign line_done = accept && last_word;
  assign start_ok  = frame_start && (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_sol   = out_valid && (out_cnt == '0);
  assign out_eol   = out_valid && last_word;
  assign out_eof   = out_eol && (line_cnt == LINE_LAST);
  assign credits   = CRED_MAX - inflight - skid_cnt;

  // Count reads still travelling through the FIFO output registers.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CRED_W'(tag_pipe[i]);
  end

  // State register.
  always_ff @(posedge rclk) begin
    if (!rrst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic and read enable; ren only ever asserted in READ.
  always_comb begin
    state_nxt = state;
    fifo_ren  = 1'b0;
    case (state)
      IDLE:      if (frame_start) state_nxt = WAIT_FILL;
      WAIT_FILL: if (!fifo_prog_empty) state_nxt = READ;
      READ: begin
        fifo_ren = !fifo_rempty && (credits != '0);
        if (fifo_ren && (rd_cnt == WORD_LAST)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (line_done) state_nxt = (line_cnt == LINE_LAST) ? IDLE : WAIT_FILL;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Issued/accepted word counters and line counter.
  always_ff @(posedge rclk) begin
    if (!rrst_n || start_ok) begin
      rd_cnt   <= '0;
      out_cnt  <= '0;
      line_cnt <= '0;
    end else begin
      if (line_done)     rd_cnt <= '0;
      else if (fifo_ren) rd_cnt <= rd_cnt + 1'b1;
      if (line_done)     out_cnt <= '0;
      else if (accept)   out_cnt <= out_cnt + 1'b1;
      if (line_done) line_cnt <= (line_cnt == LINE_LAST) ? '0 : line_cnt + 1'b1;
    end
  end

  // Tag pipeline marking which fifo_rdata cycles carry a requested word.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      tag_pipe <= '0;
    end else begin
      tag_pipe[0] <= fifo_ren;
      for (int i = 1; i < RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  // Status flags: done pulse plus sticky error bits cleared by a new frame.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      start_err  <= 1'b0;
    end else begin
      frame_done <= line_done && (line_cnt == LINE_LAST);
      if (start_ok) begin
        underrun  <= 1'b0;
        start_err <= 1'b0;
      end else begin
        if ((state == READ) && fifo_rempty) underrun  <= 1'b1;
        if (frame_start && (state != IDLE)) start_err <= 1'b1;
      end
    end
  end

  rd_skid_buf #(
    .DEPTH  (SKID_DEPTH),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk     (rclk),
    .rst_n   (rrst_n),
    .wr_en   (tag_pipe[RD_LAT-1]),
    .wr_data (fifo_rdata),
    .rd_en   (accept),
    .rd_data (skid_data),
    .count   (skid_cnt)
  );

endmodule

// File: tb/tb_fifo_line_reader.sv
// Bench for fifo_line_reader: queue-based FIFO model, stream scoreboard and
// directed plus randomized frames.
module tb_fifo_line_reader;

  localparam int DW   = 32;
  localparam int LW   = 4;
  localparam int FL   = 2;
  localparam int RL   = 2;
  localparam int SKID = RL + 2;
  localparam int FW   = LW * FL;

  logic          rclk = 1'b0;
  logic          rrst_n = 1'b0;
  logic          frame_start = 1'b0;
  logic          fifo_prog_empty;
  logic          fifo_rempty;
  logic          fifo_ren;
  logic [DW-1:0] fifo_rdata;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_sol, out_eol, out_eof;
  logic          busy, frame_done, underrun, start_err;

  always #5 rclk = ~rclk;

  fifo_line_reader #(
    .DATA_W(DW), .LINE_WORDS(LW), .FRAME_LINES(FL), .RD_LAT(RL)
  ) dut (
    .rclk(rclk), .rrst_n(rrst_n), .frame_start(frame_start),
    .fifo_prog_empty(fifo_prog_empty), .fifo_rempty(fifo_rempty),
    .fifo_ren(fifo_ren), .fifo_rdata(fifo_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sol(out_sol), .out_eol(out_eol), .out_eof(out_eof),
    .busy(busy), .frame_done(frame_done), .underrun(underrun),
    .start_err(start_err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name, input longint act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got 0x%0h (cycle %0d)", name, act, cyc);
  endtask

  always @(posedge rclk) cyc <= cyc + 1;

  // ---------------- FIFO model ----------------
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] rd_pipe[RL];
  int            q_cnt = 0;
  logic          force_pe = 1'b0, force_empty = 1'b0, glitch_empty = 1'b0;
  logic          ren_n = 1'b0;

  assign fifo_rempty     = (q_cnt == 0) || force_empty || glitch_empty;
  assign fifo_prog_empty = (q_cnt < LW) || force_pe;
  assign fifo_rdata      = rd_pipe[RL-1];

  always @(negedge rclk) ren_n = fifo_ren;

  initial begin
    for (int i = 0; i < RL; i++) rd_pipe[i] = '0;
    forever begin
      @(posedge rclk);
      #1;
      for (int i = RL - 1; i > 0; i--) rd_pipe[i] = rd_pipe[i-1];
      if (ren_n && (fifo_q.size() > 0)) rd_pipe[0] = fifo_q.pop_front();
      else                              rd_pipe[0] = $urandom;
      q_cnt = fifo_q.size();
    end
  end

  // ---------------- ready / glitch driver ----------------
  int ready_mode = 0;
  bit glitch_on  = 1'b0;

  initial begin
    forever begin
      @(posedge rclk);
      #1;
      case (ready_mode)
        1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        2:       out_ready = ($urandom_range(0, 1) == 1);
        default: out_ready = 1'b1;
      endcase
      glitch_empty = glitch_on && ($urandom_range(0, 7) == 0);
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [DW-1:0] d;
    logic          sol, eol, eof;
  } acc_t;

  logic [DW-1:0] exp_q[$];
  acc_t          acc_log[$];
  int            idx = 0;
  bit            pending_fd = 1'b0, resync = 1'b1, prev_stall = 1'b0;
  logic [DW-1:0] prev_d;
  logic [2:0]    prev_f;
  int            total_ren = 0, total_acc = 0, last_eof_cyc = 0;

  always @(negedge rclk) begin
    if (!rrst_n) begin
      resync     = 1'b1;
      prev_stall = 1'b0;
      pending_fd = 1'b0;
    end else begin
      if (resync) begin
        resync    = 1'b0;
        exp_q     = fifo_q;
        idx       = 0;
        total_ren = 0;
        total_acc = 0;
        check("reset_outputs",
              longint'({fifo_ren, out_valid, out_sol, out_eol, out_eof, busy,
                        frame_done, underrun, start_err, out_data}), 0);
      end
      check("frame_done", longint'(frame_done), longint'(pending_fd));
      pending_fd = 1'b0;
      if (prev_stall) begin
        check("hold_valid", longint'(out_valid), 1);
        check("hold_word", longint'({out_data, out_sol, out_eol, out_eof}),
              longint'({prev_d, prev_f}));
      end
      if (fifo_ren) begin
        check("ren_while_empty", longint'(fifo_rempty), 0);
        total_ren++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          fail("extra_word", longint'(out_data));
        end else begin
          check("data", longint'(out_data), longint'(exp_q.pop_front()));
        end
        check("sol", longint'(out_sol), longint'((idx % LW) == 0));
        check("eol", longint'(out_eol), longint'((idx % LW) == LW - 1));
        check("eof", longint'(out_eof), longint'(idx == FW - 1));
        acc_log.push_back('{d: out_data, sol: out_sol, eol: out_eol, eof: out_eof});
        total_acc++;
        if (idx == FW - 1) begin
          pending_fd   = 1'b1;
          last_eof_cyc = cyc;
          idx          = 0;
        end else begin
          idx++;
        end
      end
      if (fifo_ren) check("credit_limit", longint'((total_ren - total_acc) <= SKID), 1);
      prev_stall = out_valid && !out_ready;
      prev_d     = out_data;
      prev_f     = {out_sol, out_eol, out_eof};
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic preload(input int n, input logic [DW-1:0] base, input bit rnd);
    logic [DW-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = rnd ? DW'($urandom) : base + DW'(i);
      fifo_q.push_back(w);
      exp_q.push_back(w);
    end
    q_cnt = fifo_q.size();
  endtask

  task automatic start_pulse();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k;
    k = 0;
    while (!frame_done && (k < budget)) begin
      tick();
      k++;
    end
    if (frame_done) begin
      check({name, "_busy_low"}, longint'(busy), 0);
      check({name, "_done_delay"}, longint'(cyc - last_eof_cyc), 1);
    end else begin
      fail({name, "_timeout"}, longint'(k));
    end
    tick();
  endtask

  task automatic check_seq(input string name, input logic [DW-1:0] base);
    check({name, "_count"}, longint'(acc_log.size()), FW);
    for (int i = 0; i < FW; i++) begin
      if (i < acc_log.size()) begin
        check({name, "_seq"}, longint'(acc_log[i].d), longint'(base + DW'(i)));
        check({name, "_sol"}, longint'(acc_log[i].sol), longint'((i == 0) || (i == 4)));
        check({name, "_eol"}, longint'(acc_log[i].eol), longint'((i == 3) || (i == 7)));
        check({name, "_eof"}, longint'(acc_log[i].eof), longint'(i == 7));
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int k;
    repeat (3) tick();
    rrst_n = 1'b1;
    tick();
    check("idle_busy", longint'(busy), 0);
    check("idle_valid", longint'(out_valid), 0);

    // 1: straight frame, ready always high
    acc_log.delete();
    preload(8, 32'h1, 1'b0);
    start_pulse();
    wait_done("t1", 200);
    check_seq("t1", 32'h1);

    // 2: line not yet buffered, then first-word latency
    preload(8, 32'h11, 1'b0);
    force_pe = 1'b1;
    start_pulse();
    for (int i = 0; i < 20; i++) begin
      check("t2_no_ren", longint'(fifo_ren), 0);
      check("t2_busy", longint'(busy), 1);
      tick();
    end
    force_pe = 1'b0;
    k = 0;
    while (!fifo_ren && (k < 50)) begin tick(); k++; end
    if (!fifo_ren) fail("t2_ren_timeout", longint'(k));
    k = 0;
    while (!out_valid && (k < 20)) begin tick(); k++; end
    check("t2_latency", longint'(k), RL + 1);
    wait_done("t2", 200);

    // 3: ready pattern 1,0,0,1
    acc_log.delete();
    ready_mode = 1;
    preload(8, 32'h101, 1'b0);
    start_pulse();
    wait_done("t3", 300);
    check_seq("t3", 32'h101);
    ready_mode = 0;

    // 4: FIFO runs dry after two reads of line 0
    acc_log.delete();
    preload(8, 32'h201, 1'b0);
    check("t4_underrun_pre", longint'(underrun), 0);
    start_pulse();
    k = 0;
    while ((total_ren < 2) && (k < 50)) begin tick(); k++; end
    force_empty = 1'b1;
    repeat (5) tick();
    force_empty = 1'b0;
    check("t4_underrun_set", longint'(underrun), 1);
    wait_done("t4", 200);
    check("t4_underrun_sticky", longint'(underrun), 1);
    check_seq("t4", 32'h201);

    // 5: restart clears underrun; frame_start while busy flags start_err
    preload(8, 32'h301, 1'b0);
    start_pulse();
    check("t5_underrun_clr", longint'(underrun), 0);
    check("t5_start_err_clr", longint'(start_err), 0);
    k = 0;
    while (!fifo_ren && (k < 50)) begin tick(); k++; end
    start_pulse();
    check("t5_start_err", longint'(start_err), 1);
    check("t5_still_busy", longint'(busy), 1);
    wait_done("t5", 200);
    check("t5_start_err_sticky", longint'(start_err), 1);

    // 6: reset in the middle of line 1, then a fresh frame
    acc_log.delete();
    preload(8, 32'h401, 1'b0);
    start_pulse();
    k = 0;
    while ((acc_log.size() < 5) && (k < 100)) begin tick(); k++; end
    rrst_n = 1'b0;
    tick();
    rrst_n = 1'b1;
    check("t6_rst_busy", longint'(busy), 0);
    check("t6_rst_valid", longint'(out_valid), 0);
    check("t6_rst_ren", longint'(fifo_ren), 0);
    check("t6_rst_start_err", longint'(start_err), 0);
    tick();
    acc_log.delete();
    preload(8, 32'h501, 1'b0);
    start_pulse();
    wait_done("t6", 200);
    check("t6_count", longint'(acc_log.size()), FW);
    if (acc_log.size() > 0) check("t6_first_sol", longint'(acc_log[0].sol), 1);

    // randomized frames: random data, ready, fill delay and empty glitches
    for (int f = 0; f < 6; f++) begin
      ready_mode = 2;
      glitch_on  = (f % 2) == 1;
      preload(8 + $urandom_range(0, 3), '0, 1'b1);
      force_pe = 1'b1;
      start_pulse();
      repeat ($urandom_range(0, 6)) tick();
      force_pe = 1'b0;
      wait_done("rnd", 800);
      glitch_on = 1'b0;
    end
    ready_mode = 0;

    repeat (5) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
